// File: rtl/ysyx_23060171_pkg.sv
// Shared definitions for the ysyx_23060171 core: register-file geometry and
// the writeback queue entry layout used by the WBU and the GPR.
package ysyx_23060171_pkg;

    localparam int WB_ADDR_WIDTH = 5;
    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_DEPTH      = 4;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] rd;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/ysyx_23060171_wbu_if.sv
// Bundle of the writeback unit's result handshakes, GPR write port and
// forwarding query ports. The WBU is the slave; its neighbours drive master.
interface ysyx_23060171_wbu_if
    import ysyx_23060171_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH
);
    logic                  exu_valid;
    logic                  exu_ready;
    logic [ADDR_WIDTH-1:0] exu_rd;
    logic [DATA_WIDTH-1:0] exu_data;
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [ADDR_WIDTH-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_data;
    logic                  gpr_wen;
    logic [ADDR_WIDTH-1:0] gpr_waddr;
    logic [DATA_WIDTH-1:0] gpr_wdata;
    logic [ADDR_WIDTH-1:0] fwd_raddr1;
    logic [ADDR_WIDTH-1:0] fwd_raddr2;
    logic                  fwd_hit1;
    logic                  fwd_hit2;
    logic [DATA_WIDTH-1:0] fwd_data1;
    logic [DATA_WIDTH-1:0] fwd_data2;
    logic                  pending;

    modport slave (
        input  exu_valid, exu_rd, exu_data,
        output exu_ready,
        input  lsu_valid, lsu_rd, lsu_data,
        output lsu_ready,
        output gpr_wen, gpr_waddr, gpr_wdata,
        input  fwd_raddr1, fwd_raddr2,
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
        output pending
    );

    modport master (
        output exu_valid, exu_rd, exu_data,
        input  exu_ready,
        output lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready,
        input  gpr_wen, gpr_waddr, gpr_wdata,
        output fwd_raddr1, fwd_raddr2,
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
        input  pending
    );

endinterface

// File: rtl/ysyx_23060171_wbu_fwd.sv
// Youngest-match search over the writeback queue for one operand read port.
// Entries are visited oldest to youngest so the last match wins.
module ysyx_23060171_wbu_fwd
    import ysyx_23060171_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int DEPTH      = WB_DEPTH,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  wb_entry_t             entries [DEPTH],
    input  logic [DEPTH-1:0]      valid,
    input  logic [PTR_W-1:0]      head,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] data
);

    logic [PTR_W-1:0] idx_s;

    // Scan from the head (oldest) forward; x0 is never forwarded.
    always_comb begin
        hit   = 1'b0;
        data  = '0;
        idx_s = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s = head + PTR_W'(k);
            if (valid[idx_s] && (entries[idx_s].rd == raddr) && (raddr != '0)) begin
                hit  = 1'b1;
                data = entries[idx_s].data;
            end else begin
                hit  = hit;
                data = data;
            end
        end
    end

endmodule

// File: rtl/ysyx_23060171_wbu.sv
// Writeback unit: in-order queue of EXU/LSU results retired one per cycle
// into the GPR write port, with forwarding of not-yet-written values.
module ysyx_23060171_wbu
    import ysyx_23060171_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int DEPTH      = WB_DEPTH
) (
    input logic               clk,
    input logic               rst_n,
    ysyx_23060171_wbu_if.slave wb
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SPC_W = PTR_W + 2;

    wb_entry_t         entry_r [DEPTH];
    logic [DEPTH-1:0]  valid_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic              deq_s;
    logic [SPC_W-1:0]  space_s;
    logic              lsu_ready_s;
    logic              exu_ready_s;
    logic              enq_lsu_s;
    logic              enq_exu_s;
    logic [PTR_W-1:0]  exu_slot_s;
    logic [CNT_W-1:0]  count_next_s;
    logic [DEPTH-1:0]  valid_next_s;

    // Space credits the head leaving this cycle; rd==0 results are accepted but dropped.
    always_comb begin
        deq_s        = (count_r != '0);
        space_s      = SPC_W'(DEPTH) - SPC_W'(count_r) + SPC_W'(deq_s);
        lsu_ready_s  = (space_s >= SPC_W'(1));
        exu_ready_s  = (space_s >= (SPC_W'(1) + SPC_W'(wb.lsu_valid)));
        enq_lsu_s    = wb.lsu_valid && lsu_ready_s && (wb.lsu_rd != '0);
        enq_exu_s    = wb.exu_valid && exu_ready_s && (wb.exu_rd != '0);
        exu_slot_s   = wr_ptr_r + PTR_W'(enq_lsu_s);
        count_next_s = count_r + CNT_W'(enq_lsu_s) + CNT_W'(enq_exu_s) - CNT_W'(deq_s);
        valid_next_s = valid_r;
        if (deq_s) begin
            valid_next_s[rd_ptr_r] = 1'b0;
        end else begin
            valid_next_s = valid_next_s;
        end
        if (enq_lsu_s) begin
            valid_next_s[wr_ptr_r] = 1'b1;
        end else begin
            valid_next_s = valid_next_s;
        end
        if (enq_exu_s) begin
            valid_next_s[exu_slot_s] = 1'b1;
        end else begin
            valid_next_s = valid_next_s;
        end
    end

    // Queue pointers, occupancy and validity; reset discards all pending writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= '0;
        end else begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(deq_s);
            wr_ptr_r <= wr_ptr_r + PTR_W'(enq_lsu_s) + PTR_W'(enq_exu_s);
            count_r  <= count_next_s;
            valid_r  <= valid_next_s;
        end
    end

    // Entry storage; LSU takes the older slot when both sources enqueue together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= '0;
            end
        end else begin
            if (enq_lsu_s) begin
                entry_r[wr_ptr_r] <= '{rd: wb.lsu_rd, data: wb.lsu_data};
            end
            if (enq_exu_s) begin
                entry_r[exu_slot_s] <= '{rd: wb.exu_rd, data: wb.exu_data};
            end
        end
    end

    assign wb.lsu_ready = lsu_ready_s;
    assign wb.exu_ready = exu_ready_s;
    assign wb.gpr_wen   = deq_s;
    assign wb.gpr_waddr = entry_r[rd_ptr_r].rd;
    assign wb.gpr_wdata = entry_r[rd_ptr_r].data;
    assign wb.pending   = deq_s;

    ysyx_23060171_wbu_fwd #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fwd1 (
        .entries (entry_r),
        .valid   (valid_r),
        .head    (rd_ptr_r),
        .raddr   (wb.fwd_raddr1),
        .hit     (wb.fwd_hit1),
        .data    (wb.fwd_data1)
    );

    ysyx_23060171_wbu_fwd #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fwd2 (
        .entries (entry_r),
        .valid   (valid_r),
        .head    (rd_ptr_r),
        .raddr   (wb.fwd_raddr2),
        .hit     (wb.fwd_hit2),
        .data    (wb.fwd_data2)
    );

endmodule

// File: tb/tb_ysyx_23060171_wbu.sv
// Directed and random stimulus for the writeback unit, checked against a
// queue-based reference of pending GPR writes.
module tb_ysyx_23060171_wbu;
    import ysyx_23060171_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ysyx_23060171_wbu_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ysyx_23060171_wbu #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    wb_entry_t sb [$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_fwd(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] data);
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < sb.size(); i++) begin
            if (a != '0 && sb[i].rd == a) begin
                hit  = 1'b1;
                data = sb[i].data;
            end
        end
    endtask

    task automatic drive(input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                         input logic ev, input logic [AW-1:0] erd, input logic [DW-1:0] ed);
        bus.lsu_valid = lv;
        bus.lsu_rd    = lrd;
        bus.lsu_data  = ld;
        bus.exu_valid = ev;
        bus.exu_rd    = erd;
        bus.exu_data  = ed;
    endtask

    // Check all outputs mid-cycle against the model, then advance the model across the edge.
    task automatic cycle();
        int cnt, space;
        logic exp_lr, exp_er, acc_l, acc_e, h;
        logic [DW-1:0] d;
        @(negedge clk);
        cnt    = sb.size();
        space  = DEPTH - cnt + ((cnt != 0) ? 1 : 0);
        exp_lr = (space >= 1);
        exp_er = (space >= 1 + (bus.lsu_valid ? 1 : 0));
        chk("gpr_wen", DW'(bus.gpr_wen), DW'(cnt != 0));
        chk("pending", DW'(bus.pending), DW'(cnt != 0));
        if (cnt != 0) begin
            chk("gpr_waddr", DW'(bus.gpr_waddr), DW'(sb[0].rd));
            chk("gpr_wdata", bus.gpr_wdata, sb[0].data);
        end
        chk("lsu_ready", DW'(bus.lsu_ready), DW'(exp_lr));
        chk("exu_ready", DW'(bus.exu_ready), DW'(exp_er));
        model_fwd(bus.fwd_raddr1, h, d);
        chk("fwd_hit1", DW'(bus.fwd_hit1), DW'(h));
        chk("fwd_data1", bus.fwd_data1, d);
        model_fwd(bus.fwd_raddr2, h, d);
        chk("fwd_hit2", DW'(bus.fwd_hit2), DW'(h));
        chk("fwd_data2", bus.fwd_data2, d);
        acc_l = bus.lsu_valid && exp_lr && rst_n;
        acc_e = bus.exu_valid && exp_er && rst_n;
        @(posedge clk);
        if (cnt != 0 && rst_n) sb.pop_front();
        if (acc_l && bus.lsu_rd != '0) sb.push_back('{rd: bus.lsu_rd, data: bus.lsu_data});
        if (acc_e && bus.exu_rd != '0) sb.push_back('{rd: bus.exu_rd, data: bus.exu_data});
        #1;
    endtask

    task automatic drain();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 12 && sb.size() != 0; i++) cycle();
        chk("drained", DW'(sb.size()), DW'(0));
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.fwd_raddr1 = '0;
        bus.fwd_raddr2 = '0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();

        // Single EXU write, visible on GPR port and via forwarding next cycle
        bus.fwd_raddr1 = 5'd5;
        drive(1'b0, '0, '0, 1'b1, 5'd5, 32'h0000_1234);
        cycle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        cycle();
        cycle();

        // Same-cycle LSU and EXU to one register: LSU retires first, EXU value forwarded
        bus.fwd_raddr1 = 5'd3;
        bus.fwd_raddr2 = 5'd5;
        drive(1'b1, 5'd3, 32'h0000_00AA, 1'b1, 5'd3, 32'h0000_00BB);
        cycle();
        drain();

        // Saturation with both sources always valid, many pointer wraps
        for (int i = 0; i < 24; i++) begin
            bus.fwd_raddr1 = AW'((i % 31) + 1);
            bus.fwd_raddr2 = AW'(((i + 5) % 31) + 1);
            drive(1'b1, AW'((i % 31) + 1), 32'h1000 + DW'(i),
                  1'b1, AW'(((i + 7) % 31) + 1), 32'h2000 + DW'(i));
            cycle();
        end
        chk("sat_count", DW'(sb.size()), DW'(DEPTH));
        drain();

        // rd==0 handshake: accepted, nothing queued, x0 never forwarded
        bus.fwd_raddr1 = '0;
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h0000_FFFF);
        cycle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        cycle();

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            bus.fwd_raddr1 = AW'($urandom_range(0, 7));
            bus.fwd_raddr2 = AW'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
            cycle();
        end
        drain();

        // Reset with three writes queued
        bus.fwd_raddr1 = 5'd8;
        drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88);
        cycle();
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hA0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        chk("pre_rst_count", DW'(sb.size()), DW'(3));
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("rst_gpr_wen", DW'(bus.gpr_wen), DW'(0));
        chk("rst_pending", DW'(bus.pending), DW'(0));
        chk("rst_lsu_ready", DW'(bus.lsu_ready), DW'(1));
        chk("rst_exu_ready", DW'(bus.exu_ready), DW'(1));
        chk("rst_fwd_hit1", DW'(bus.fwd_hit1), DW'(0));
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
